noise_smp: RTL

NOISE_SMP -- requirements
Module: noise_smp

---
 rtl/noise_pkg.sv | 12 +
 rtl/noise_smp_fifo.sv | 51 +++++
 rtl/noise_smp.sv | 133 +++++++++++++
 3 files changed

// File: rtl/noise_pkg.sv
// Shared types and default widths for the noise-sample block accumulator.
package noise_pkg;

  localparam int unsigned DW_DEF = 12;
  localparam int unsigned CW_DEF = 10;

  typedef enum logic {
    IDLE = 1'b0,
    ACQ  = 1'b1
  } state_t;

endpackage

// File: rtl/noise_smp_fifo.sv
// Two-entry first-in-first-out buffer for completed block sums.
module noise_smp_fifo #(
  parameter int unsigned W = 22
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign data_out = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Caller only pushes when there is room (or a pop frees the head this cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noise_smp.sv
// Noise sample accumulator: sums num_smp ADC samples per block on noise_clk rises.
// Optional NOISE_SMP_OVF_EN adds a sticky ovf flag for dropped block sums.
module noise_smp
  import noise_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned CW = CW_DEF,
  localparam int unsigned SW = DW + CW
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          n_acq_en,
  input  logic          noise_clk,
  input  logic [DW-1:0] adc_data,
  input  logic [CW-1:0] num_smp,
  input  logic          start,
  output logic          busy,
  output logic [SW-1:0] sum_data,
  output logic          sum_valid,
  input  logic          sum_ready,
  output logic          blk_done
`ifdef NOISE_SMP_OVF_EN
  ,
  output logic          ovf
`endif
);

  state_t        state;
  state_t        state_nxt;
  logic          nclk_d;
  logic          rise;
  logic          last_rise;
  logic [SW-1:0] acc;
  logic [SW-1:0] sum_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lim;
  logic          push_q;
  logic          wr;
  logic          rd;
  logic          full;
  logic          empty;

  assign rise      = noise_clk & ~nclk_d;
  assign last_rise = (state == ACQ) && n_acq_en && rise && ((cnt + CW'(1)) == lim);
  assign busy      = (state == ACQ);
  assign blk_done  = push_q;
  assign sum_valid = ~empty;
  assign rd        = sum_ready & ~empty;
  assign wr        = push_q & (~full | rd);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && n_acq_en) state_nxt = ACQ;
      ACQ:     if (!n_acq_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The final sample is folded into sum_q directly, so acc can restart the next block.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      nclk_d <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      lim    <= CW'(1);
      sum_q  <= '0;
      push_q <= 1'b0;
    end else begin
      nclk_d <= noise_clk;
      push_q <= last_rise;
      if (last_rise) begin
        sum_q <= acc + SW'(adc_data);
      end
      case (state)
        IDLE: begin
          if (start && n_acq_en) begin
            lim <= (num_smp == '0) ? CW'(1) : num_smp;
            acc <= '0;
            cnt <= '0;
          end
        end
        ACQ: begin
          if (!n_acq_en || last_rise) begin
            acc <= '0;
            cnt <= '0;
          end else if (rise) begin
            acc <= acc + SW'(adc_data);
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          acc <= '0;
          cnt <= '0;
        end
      endcase
    end
  end

  noise_smp_fifo #(
    .W(SW)
  ) u_fifo (
    .clk      (clk_sys),
    .rst      (rst),
    .push     (wr),
    .pop      (rd),
    .data_in  (sum_q),
    .data_out (sum_data),
    .full     (full),
    .empty    (empty)
  );

`ifdef NOISE_SMP_OVF_EN
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (push_q && !wr) begin
      ovf <= 1'b1;
    end else if (start) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule
